// File: rtl/button_pkg.sv
// button_pkg: shared types and timing defaults for the button conditioner
//   btn_state_e         : per-channel debounce FSM state
//   CLK_HZ              : system clock frequency
//   DEBOUNCE_CYCLES_DEF : 10 ms settle time at CLK_HZ
//   LONG_CYCLES_DEF     : 1 s long-press threshold at CLK_HZ
package button_pkg;
    typedef enum logic [1:0] {IDLE, ARM, DOWN, REL} btn_state_e;
    localparam int CLK_HZ = 27_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    localparam int LONG_CYCLES_DEF = CLK_HZ;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw pin inputs and conditioned event outputs for N buttons
//   buttons    : raw asynchronous pin levels
//   level      : debounced state, 1 = pressed
//   pressed    : 1-cycle pulse on accepted press
//   released   : 1-cycle pulse on accepted release
//   long_press : 1-cycle pulse once per long hold
//   held_long  : high from long_press until the release is accepted
//   master drives the pins, slave is the conditioner
interface button_conditioner_if #(
    parameter int N_BUTTONS = 2
);
    logic [N_BUTTONS-1:0] buttons;
    logic [N_BUTTONS-1:0] level;
    logic [N_BUTTONS-1:0] pressed;
    logic [N_BUTTONS-1:0] released;
    logic [N_BUTTONS-1:0] long_press;
    logic [N_BUTTONS-1:0] held_long;

    modport master (output buttons, input level, pressed, released, long_press, held_long);
    modport slave  (input buttons, output level, pressed, released, long_press, held_long);
endinterface

// File: rtl/button_debounce_channel.sv
// button_debounce_channel: synchronise, debounce and classify one push-button
//   clk, rst_n     : clock, asynchronous active-low reset
//   button_i       : raw pin level
//   level_o        : debounced state, 1 = pressed
//   pressed_o      : 1-cycle pulse on accepted press
//   released_o     : 1-cycle pulse on accepted release
//   long_press_o   : 1-cycle pulse LONG_CYCLES after pressed_o
//   held_long_o    : high from long_press_o until release is accepted
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic level_o,
    output logic pressed_o,
    output logic released_o,
    output logic long_press_o,
    output logic held_long_o
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic IDLE_PIN = ACTIVE_LOW;

    btn_state_e    state_q, state_d;
    logic [1:0]    sync_q;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d, pressed_q, pressed_d, released_q, released_d;
    logic          long_q, long_d, held_q, held_d;
    logic          act;

    assign act = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        state_d    = state_q;
        deb_d      = deb_q;
        level_d    = level_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        // hold counter runs in DOWN and REL alike; the long pulse fires one
        // cycle after it settles on its terminal value, so exactly LONG_CYCLES
        // after pressed, and held_long keeps it from repeating
        hold_d = (level_q && hold_q != HOLD_LAST) ? hold_q + 1'b1 : hold_q;
        long_d = level_q && hold_q == HOLD_LAST && !held_q;
        held_d = held_q | long_d;
        case (state_q)
            IDLE: if (act) begin
                state_d = ARM;
                deb_d   = '0;
            end
            ARM: if (!act) state_d = IDLE;
            else if (deb_q == DEB_LAST) begin
                state_d   = DOWN;
                level_d   = 1'b1;
                pressed_d = 1'b1;
                hold_d    = '0;
            end else deb_d = deb_q + 1'b1;
            DOWN: if (!act) begin
                state_d = REL;
                deb_d   = '0;
            end
            REL: if (act) state_d = DOWN;
            else if (deb_q == DEB_LAST) begin
                // release acceptance overrides a long pulse due on the same edge
                state_d    = IDLE;
                level_d    = 1'b0;
                released_d = 1'b1;
                long_d     = 1'b0;
                held_d     = 1'b0;
            end else deb_d = deb_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= {2{IDLE_PIN}};
            state_q    <= IDLE;
            deb_q      <= '0;
            hold_q     <= '0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], button_i};
            state_q    <= state_d;
            deb_q      <= deb_d;
            hold_q     <= hold_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            long_q     <= long_d;
            held_q     <= held_d;
        end
    end

    assign level_o      = level_q;
    assign pressed_o    = pressed_q;
    assign released_o   = released_q;
    assign long_press_o = long_q;
    assign held_long_o  = held_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N independent debounced button channels
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : raw pins in, conditioned level/pulse outputs out
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input logic clk,
    input logic rst_n,
    button_conditioner_if.slave bus
);
    logic [N_BUTTONS-1:0] level, pressed, released, long_press, held_long;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .button_i    (bus.buttons[i]),
            .level_o     (level[i]),
            .pressed_o   (pressed[i]),
            .released_o  (released[i]),
            .long_press_o(long_press[i]),
            .held_long_o (held_long[i])
        );
    end

    assign bus.level      = level;
    assign bus.pressed    = pressed;
    assign bus.released   = released;
    assign bus.long_press = long_press;
    assign bus.held_long  = held_long;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks against a run-length reference model
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    button_conditioner_if #(.N_BUTTONS(2)) bif ();

    button_conditioner #(
        .N_BUTTONS      (2),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;

    // Reference: a new pin state is accepted once D+1 consecutive synchronised
    // samples disagree with the accepted level; long fires L cycles after a
    // press unless the release is accepted on that same edge.
    logic [1:0] d1, d2, lvl, held, ep, er, el, tog;
    int run [2];
    int age [2];

    always_comb for (int i = 0; i < 2; i++) tog[i] = (d2[i] != lvl[i]) && run[i] == D;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0; d2 <= '0; lvl <= '0; held <= '0; ep <= '0; er <= '0; el <= '0;
            for (int i = 0; i < 2; i++) begin
                run[i] <= 0;
                age[i] <= 0;
            end
        end else begin
            d1 <= ~bif.buttons;
            d2 <= d1;
            for (int i = 0; i < 2; i++) begin
                run[i]  <= (d2[i] != lvl[i] && !tog[i]) ? run[i] + 1 : 0;
                age[i]  <= (tog[i] && !lvl[i]) ? 0 : age[i] + 1;
                lvl[i]  <= lvl[i] ^ tog[i];
                ep[i]   <= tog[i] && !lvl[i];
                er[i]   <= tog[i] && lvl[i];
                el[i]   <= lvl[i] && age[i] == L - 1 && !tog[i];
                held[i] <= (tog[i] && lvl[i]) ? 1'b0 : (held[i] | (lvl[i] && age[i] == L - 1));
            end
        end
    end

    logic [9:0] obs, expv;
    assign obs  = {bif.level, bif.pressed, bif.released, bif.long_press, bif.held_long};
    assign expv = {lvl, ep, er, el, held};

    task automatic test_reset();
        rst_n = 1'b0;
        bif.buttons = 2'b11;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs !== 10'b0) $display("FAIL reset_state got %b want %b", obs, 10'b0);
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL reset_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int pk = 0, lk = 0, rk = 0;
        bif.buttons[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL clean_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            if (bif.pressed[0] && pk == 0) pk = k;
            if (bif.long_press[0] && lk == 0) lk = k;
        end
        n_chk++;
        if (pk !== 7) $display("FAIL clean_press_latency got %0d want 7", pk);
        else n_pass++;
        n_chk++;
        if (lk - pk !== L) $display("FAIL clean_long_delay got %0d want %0d", lk - pk, L);
        else n_pass++;
        n_chk++;
        if ({bif.level[0], bif.held_long[0]} !== 2'b11) $display("FAIL clean_held got %b want 11", {bif.level[0], bif.held_long[0]});
        else n_pass++;
        bif.buttons[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL clean_rel_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            if (bif.released[0] && rk == 0) rk = k;
        end
        n_chk++;
        if (rk !== 7) $display("FAIL clean_release_latency got %0d want 7", rk);
        else n_pass++;
        n_chk++;
        if ({bif.level[0], bif.held_long[0]} !== 2'b00) $display("FAIL clean_cleared got %b want 00", {bif.level[0], bif.held_long[0]});
        else n_pass++;
    endtask

    task automatic test_bounce();
        int np = 0, pk = 0;
        repeat (2) begin
            bif.buttons[0] = 1'b0;
            repeat (3) begin
                @(negedge clk);
                n_chk++;
                if (obs !== expv) $display("FAIL bounce_trace t=%0t got %b want %b", $time, obs, expv);
                else n_pass++;
                np += int'(bif.pressed[0]);
            end
            bif.buttons[0] = 1'b1;
            repeat (2) begin
                @(negedge clk);
                n_chk++;
                if (obs !== expv) $display("FAIL bounce_trace t=%0t got %b want %b", $time, obs, expv);
                else n_pass++;
                np += int'(bif.pressed[0]);
            end
        end
        bif.buttons[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL bounce_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            np += int'(bif.pressed[0]);
            if (bif.pressed[0] && pk == 0) pk = k;
        end
        n_chk++;
        if (np !== 1) $display("FAIL bounce_press_count got %0d want 1", np);
        else n_pass++;
        n_chk++;
        if (pk !== 7) $display("FAIL bounce_press_latency got %0d want 7", pk);
        else n_pass++;
        bif.buttons[0] = 1'b1;
        repeat (12) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL bounce_rel_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
    endtask

    // release pin goes inactive 'gap' cycles after pressed, so acceptance
    // lands gap+D+3 edges after pressed
    task automatic test_release_timing(input int gap, input int want_long);
        int k = 0, rk = 0, nl = 0;
        bif.buttons[0] = 1'b0;
        while (!bif.pressed[0] && k < 20) begin
            @(negedge clk);
            k++;
            n_chk++;
            if (obs !== expv) $display("FAIL rel_timing_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (bif.pressed[0] !== 1'b1) $display("FAIL rel_timing_press got %b want 1", bif.pressed[0]);
        else n_pass++;
        repeat (gap) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL rel_timing_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            nl += int'(bif.long_press[0]);
        end
        bif.buttons[0] = 1'b1;
        for (int j = gap + 1; j <= gap + D + 10; j++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL rel_timing_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            nl += int'(bif.long_press[0]);
            if (bif.released[0] && rk == 0) rk = j;
        end
        n_chk++;
        if (rk !== gap + D + 3) $display("FAIL rel_timing_release gap=%0d got %0d want %0d", gap, rk, gap + D + 3);
        else n_pass++;
        n_chk++;
        if (nl !== want_long) $display("FAIL rel_timing_long gap=%0d got %0d want %0d", gap, nl, want_long);
        else n_pass++;
    endtask

    task automatic test_independence();
        int p0 = 0, p1 = 0, l0 = 0, l1 = 0;
        bif.buttons[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL indep_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            if (bif.pressed[0] && p0 == 0) p0 = k;
            if (bif.pressed[1] && p1 == 0) p1 = k;
            if (bif.long_press[0] && l0 == 0) l0 = k;
            if (bif.long_press[1] && l1 == 0) l1 = k;
            if (k == 2) bif.buttons[1] = 1'b0;
        end
        n_chk++;
        if ({p0, p1} !== {32'd7, 32'd9}) $display("FAIL indep_press got %0d,%0d want 7,9", p0, p1);
        else n_pass++;
        n_chk++;
        if ({l0, l1} !== {32'd27, 32'd29}) $display("FAIL indep_long got %0d,%0d want 27,29", l0, l1);
        else n_pass++;
        bif.buttons = 2'b11;
        repeat (12) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL indep_rel_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (bif.level !== 2'b00) $display("FAIL indep_idle got %b want 00", bif.level);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int k = 0, pk = 0;
        bif.buttons[1] = 1'b0;
        while (!bif.level[1] && k < 20) begin
            @(negedge clk);
            k++;
            n_chk++;
            if (obs !== expv) $display("FAIL rst_hold_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (bif.level[1] !== 1'b1) $display("FAIL rst_hold_level got %b want 1", bif.level[1]);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 10'b0) $display("FAIL rst_hold_async got %b want %b", obs, 10'b0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL rst_hold_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            if (bif.pressed[1] && pk == 0) pk = j;
        end
        n_chk++;
        if (pk !== 7) $display("FAIL rst_hold_repress got %0d want 7", pk);
        else n_pass++;
        bif.buttons = 2'b11;
        repeat (12) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL rst_hold_rel_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int rem [2] = '{1, 1};
        repeat (1500) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL random_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
            for (int i = 0; i < 2; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    bif.buttons[i] = ~bif.buttons[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(1, 6));
                end
            end
        end
        bif.buttons = 2'b11;
        repeat (15) begin
            @(negedge clk);
            n_chk++;
            if (obs !== expv) $display("FAIL random_tail_trace t=%0t got %b want %b", $time, obs, expv);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_timing(3, 0);
        test_release_timing(L - D - 3, 0);
        test_release_timing(L - D - 2, 1);
        test_independence();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
